fetch_queue: RTL and testbench

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_queue_pkg.sv | 22 ++
 rtl/fetch_fifo.sv | 70 +++++++
 rtl/fetch_queue.sv | 93 +++++++++
 tb/tb_fetch_queue.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_queue_pkg.sv
// Shared processor package for the instruction-fetch front end.
// Holds the fetch defaults, the NOP encoding and the queue-entry record.
package fetch_queue_pkg;

  localparam logic [31:0] FQ_RESET_PC = 32'h0000_0000;
  localparam int unsigned FQ_DEPTH    = 4;
  localparam logic [31:0] NOP_INST    = 32'h0000_0013;
  localparam int unsigned ENTRY_W     = 96;

  // One fetched instruction as it travels toward IF/ID.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] inst;
  } fq_entry_t;

  // Force an address onto a word boundary.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Storage for fetched instructions: circular buffer with occupancy count.
// Ports:
//   clk, rst_n        clock and async active-low reset
//   i_flush           synchronous clear of all entries (wins over push/pop)
//   i_push/i_push_data  write one entry at the tail
//   i_pop             drop the head entry
//   o_head/o_valid    head entry and its presence
//   o_count           number of entries held
module fetch_fifo
  import fetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH = FQ_DEPTH,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_flush,
  input  logic             i_push,
  input  fq_entry_t        i_push_data,
  input  logic             i_pop,
  output fq_entry_t        o_head,
  output logic             o_valid,
  output logic [CNT_W-1:0] o_count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [ENTRY_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_count;
  logic               w_pop;

  // Pointer increment that also works for non-power-of-two depths.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign w_pop = i_pop & o_valid;

  // The producer's credit scheme guarantees no push ever lands on a full buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_push_data;
        r_wr_ptr        <= ptr_inc(r_wr_ptr);
      end
      if (w_pop) r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({i_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head  = fq_entry_t'(r_mem[r_rd_ptr]);
  assign o_valid = (r_count != '0);
  assign o_count = r_count;

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch unit: issues word reads, queues returned instructions
// and presents them to IF/ID with a valid/ready handshake. A taken
// redirect flushes the queue, kills the outstanding read and refetches.
// Ports:
//   clk, rst_n                 clock and async active-low reset
//   imem_req/imem_addr         read strobe and word address
//   imem_rdata                 instruction, one cycle after imem_req
//   redirect/redirect_pc       taken control transfer and its target
//   out_valid/out_ready        handshake toward IF/ID
//   out_pc/out_pc4/out_inst    head entry
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter logic [31:0] RESET_PC = FQ_RESET_PC,
  parameter int unsigned DEPTH    = FQ_DEPTH
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_pc4,
  output logic [31:0] out_inst
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned SUM_W = CNT_W + 1;

  logic [31:0]      r_fetch_pc;
  logic [31:0]      r_tag;
  logic             r_inflight;
  logic [CNT_W-1:0] w_count;
  logic             w_credit;
  logic             w_req;
  logic             w_push;
  logic             w_pop;
  fq_entry_t        w_push_data;
  fq_entry_t        w_head;

  // A read is only issued if its response is guaranteed a free slot.
  assign w_credit = (SUM_W'(w_count) + SUM_W'(r_inflight)) < SUM_W'(DEPTH);
  assign w_req    = w_credit & ~redirect;
  assign imem_req = rst_n & w_req;
  assign imem_addr = r_fetch_pc;

  // A response landing in a redirect cycle belongs to the wrong path.
  assign w_push = r_inflight & ~redirect;
  assign w_pop  = out_valid & out_ready;

  assign w_push_data = '{pc: r_tag, pc4: r_tag + 32'd4, inst: imem_rdata};

  // Fetch PC, outstanding-read flag and its tag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_pc <= RESET_PC;
      r_tag      <= '0;
      r_inflight <= 1'b0;
    end else if (redirect) begin
      r_fetch_pc <= word_align(redirect_pc);
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_req;
      if (w_req) begin
        r_tag      <= r_fetch_pc;
        r_fetch_pc <= r_fetch_pc + 32'd4;
      end
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_flush     (redirect),
    .i_push      (w_push),
    .i_push_data (w_push_data),
    .i_pop       (w_pop),
    .o_head      (w_head),
    .o_valid     (out_valid),
    .o_count     (w_count)
  );

  assign out_pc   = w_head.pc;
  assign out_pc4  = w_head.pc4;
  assign out_inst = w_head.inst;

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed tables/sequences plus randomized traffic
// checked by a stream-level reference model.
module tb_fetch_queue;
  import fetch_queue_pkg::*;

  localparam int          DEPTH   = 4;
  localparam logic [31:0] KEY     = 32'hA5A5_A5A5;
  localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req, imem_req2;
  logic [31:0] imem_addr, imem_addr2;
  logic [31:0] imem_rdata = 32'h0, imem_rdata2 = 32'h0;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        out_valid, out_valid2;
  logic        out_ready;
  logic [31:0] out_pc, out_pc4, out_inst;
  logic [31:0] out_pc_2, out_pc4_2, out_inst_2;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fetch_queue u_dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .redirect(redirect), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_pc4(out_pc4), .out_inst(out_inst)
  );

  fetch_queue #(.RESET_PC(WRAP_PC), .DEPTH(DEPTH)) u_dut_wrap (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req2), .imem_addr(imem_addr2),
    .imem_rdata(imem_rdata2), .redirect(redirect), .redirect_pc(redirect_pc),
    .out_valid(out_valid2), .out_ready(out_ready), .out_pc(out_pc_2),
    .out_pc4(out_pc4_2), .out_inst(out_inst_2)
  );

  // Instruction memory: word content derived from its address, one-cycle latency.
  always @(posedge clk) begin
    imem_rdata  <= imem_req  ? (imem_addr  ^ KEY) : NOP_INST;
    imem_rdata2 <= imem_req2 ? (imem_addr2 ^ KEY) : NOP_INST;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %08h expected %08h", name, $time, act, exp);
    end
  endtask

  // Reference model: the delivered stream is a run of consecutive words from
  // the last reset/redirect target; requests walk the same run ahead of it.
  logic [31:0] m_req_pc, m_out_pc, m_hold_pc, m_hold_pc4, m_hold_inst;
  bit          m_stall;
  int          m_pend;
  int          m_pops;

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_imem_req", 32'(imem_req), 32'd0);
      m_req_pc = FQ_RESET_PC;
      m_out_pc = FQ_RESET_PC;
      m_pend   = 0;
      m_stall  = 0;
    end else begin
      if (m_stall) begin
        chk("stall_valid", 32'(out_valid), 32'd1);
        chk("stall_pc", out_pc, m_hold_pc);
        chk("stall_pc4", out_pc4, m_hold_pc4);
        chk("stall_inst", out_inst, m_hold_inst);
      end
      if (imem_req) begin
        chk("req_during_redirect", 32'(redirect), 32'd0);
        chk("req_addr", imem_addr, m_req_pc);
      end
      if (out_valid && out_ready) begin
        chk("pop_pc", out_pc, m_out_pc);
        chk("pop_pc4", out_pc4, m_out_pc + 32'd4);
        chk("pop_inst", out_inst, m_out_pc ^ KEY);
        m_out_pc = m_out_pc + 32'd4;
        m_pops++;
      end
      if (redirect) m_pend = 0;
      else m_pend = m_pend + (imem_req ? 1 : 0) - ((out_valid && out_ready) ? 1 : 0);
      chk("credit_no_overflow", 32'(m_pend <= DEPTH), 32'd1);
      m_stall     = out_valid && !out_ready && !redirect;
      m_hold_pc   = out_pc;
      m_hold_pc4  = out_pc4;
      m_hold_inst = out_inst;
      if (redirect) begin
        m_req_pc = redirect_pc & 32'hFFFF_FFFC;
        m_out_pc = m_req_pc;
      end else if (imem_req) begin
        m_req_pc = m_req_pc + 32'd4;
      end
    end
  end

  typedef struct {
    logic        ready;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t tbl[15];

  function automatic vec_t mk(logic r, logic q, logic [31:0] a, logic v, logic [31:0] p);
    vec_t t;
    t.ready = r; t.exp_req = q; t.exp_addr = a; t.exp_valid = v; t.exp_pc = p;
    return t;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench 1 time unit into the first cycle after reset release.
  task automatic do_reset();
    rst_n = 1'b0; out_ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int base_pops;
    rst_n = 1'b0; out_ready = 1'b0; redirect = 1'b0; redirect_pc = '0;

    // Stall from reset, then release: four reads fill the credit, nothing lost.
    tbl[0]  = mk(0, 1, 32'd0,  0, 32'd0);
    tbl[1]  = mk(0, 1, 32'd4,  0, 32'd0);
    tbl[2]  = mk(0, 1, 32'd8,  1, 32'd0);
    tbl[3]  = mk(0, 1, 32'd12, 1, 32'd0);
    tbl[4]  = mk(0, 0, 32'd16, 1, 32'd0);
    tbl[5]  = mk(0, 0, 32'd16, 1, 32'd0);
    tbl[6]  = mk(0, 0, 32'd16, 1, 32'd0);
    tbl[7]  = mk(0, 0, 32'd16, 1, 32'd0);
    tbl[8]  = mk(0, 0, 32'd16, 1, 32'd0);
    tbl[9]  = mk(0, 0, 32'd16, 1, 32'd0);
    tbl[10] = mk(1, 0, 32'd16, 1, 32'd0);
    tbl[11] = mk(1, 1, 32'd16, 1, 32'd4);
    tbl[12] = mk(1, 1, 32'd20, 1, 32'd8);
    tbl[13] = mk(1, 1, 32'd24, 1, 32'd12);
    tbl[14] = mk(1, 1, 32'd28, 1, 32'd16);

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_addr_wrap", imem_addr2, WRAP_PC);
    chk("rst_pc", out_pc, 32'h0);
    chk("rst_pc4", out_pc4, 32'h0);
    chk("rst_inst", out_inst, 32'h0);

    next_cycle();
    rst_n = 1'b1;
    for (int c = 0; c < 15; c++) begin
      out_ready = tbl[c].ready;
      @(negedge clk);
      chk($sformatf("tbl%0d_req", c), 32'(imem_req), 32'(tbl[c].exp_req));
      chk($sformatf("tbl%0d_addr", c), imem_addr, tbl[c].exp_addr);
      chk($sformatf("tbl%0d_valid", c), 32'(out_valid), 32'(tbl[c].exp_valid));
      chk($sformatf("tbl%0d_pc", c), out_pc, tbl[c].exp_pc);
      next_cycle();
    end

    // Redirect with three entries queued and one read outstanding.
    do_reset();
    repeat (4) begin @(negedge clk); next_cycle(); end
    redirect = 1'b1; redirect_pc = 32'h0000_0103;
    @(negedge clk);
    chk("rd1_req_off", 32'(imem_req), 32'd0);
    next_cycle();
    redirect = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("rd1_req", 32'(imem_req), 32'd1);
    chk("rd1_addr", imem_addr, 32'h0000_0100);
    chk("rd1_valid_t1", 32'(out_valid), 32'd0);
    next_cycle();
    @(negedge clk);
    chk("rd1_valid_t2", 32'(out_valid), 32'd0);
    next_cycle();
    @(negedge clk);
    chk("rd1_valid_t3", 32'(out_valid), 32'd1);
    chk("rd1_pc", out_pc, 32'h0000_0100);
    chk("rd1_inst", out_inst, 32'h0000_0100 ^ KEY);
    repeat (5) next_cycle();

    // Back-to-back redirects: only the second target is fetched.
    redirect = 1'b1; redirect_pc = 32'h0000_0200;
    @(negedge clk);
    chk("rd2_req_off_a", 32'(imem_req), 32'd0);
    next_cycle();
    redirect_pc = 32'h0000_0300;
    @(negedge clk);
    chk("rd2_req_off_b", 32'(imem_req), 32'd0);
    next_cycle();
    redirect = 1'b0;
    @(negedge clk);
    chk("rd2_addr", imem_addr, 32'h0000_0300);
    next_cycle();
    next_cycle();
    @(negedge clk);
    chk("rd2_valid", 32'(out_valid), 32'd1);
    chk("rd2_pc", out_pc, 32'h0000_0300);
    next_cycle();

    // Free-running from reset; second instance wraps past the top of memory.
    do_reset();
    out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk($sformatf("run%0d_addr", c), imem_addr, 32'(4 * c));
      chk($sformatf("run%0d_valid", c), 32'(out_valid), 32'(c >= 2));
      chk($sformatf("wrap%0d_valid", c), 32'(out_valid2), 32'(c >= 2));
      if (c >= 2) begin
        chk($sformatf("run%0d_pc", c), out_pc, 32'(4 * (c - 2)));
        chk($sformatf("wrap%0d_pc", c), out_pc_2, WRAP_PC + 32'(4 * (c - 2)));
        chk($sformatf("wrap%0d_pc4", c), out_pc4_2, WRAP_PC + 32'(4 * (c - 1)));
        chk($sformatf("wrap%0d_inst", c), out_inst_2, (WRAP_PC + 32'(4 * (c - 2))) ^ KEY);
      end
      next_cycle();
    end

    // Reset mid-stream with a read outstanding.
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_req", 32'(imem_req), 32'd0);
    chk("mid_rst_addr", imem_addr, FQ_RESET_PC);
    next_cycle();
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk($sformatf("restart%0d_valid", c), 32'(out_valid), 32'(c >= 2));
      if (c >= 2) begin
        chk($sformatf("restart%0d_pc", c), out_pc, 32'(4 * (c - 2)));
        chk($sformatf("restart%0d_inst", c), out_inst, 32'(4 * (c - 2)) ^ KEY);
      end
      next_cycle();
    end

    // Randomized traffic against the stream model.
    base_pops = m_pops;
    for (int i = 0; i < 3000; i++) begin
      out_ready   = ($urandom_range(3) != 0);
      redirect    = ($urandom_range(15) == 0);
      redirect_pc = $urandom;
      @(negedge clk);
      next_cycle();
    end
    redirect = 1'b0;
    chk("random_throughput", 32'(m_pops - base_pops > 600), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
